// File: rtl/dense_relu_engine_pkg.sv
// Shared types and helpers for the dense matrix-multiply + ReLU engine.
package dense_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Working width of the requantiser; any accumulator is sign-extended into it.
    localparam int unsigned SAT_W = 64;

    // Number of lane groups needed to cover every output element.
    function automatic int unsigned calc_groups(input int unsigned out_features,
                                                input int unsigned lanes);
        return out_features / lanes;
    endfunction

    // Address/counter width with a floor of one bit.
    function automatic int unsigned calc_addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Arithmetic shift, then ReLU clamp or signed saturation to n bits.
    function automatic logic signed [SAT_W-1:0] sat_requant(
        input logic signed [SAT_W-1:0] acc,
        input logic                    relu_en,
        input int unsigned             n,
        input int unsigned             shift
    );
        logic signed [SAT_W-1:0] r;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        r     = acc >>> shift;
        max_v = (64'sd1 <<< (n - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (n - 1));
        if (relu_en) begin
            if (r < 64'sd0) begin
                r = 64'sd0;
            end else if (r > max_v) begin
                r = max_v;
            end
        end else begin
            if (r > max_v) begin
                r = max_v;
            end else if (r < min_v) begin
                r = min_v;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dense_relu_engine_mac_lane.sv
// One signed multiply-accumulate lane with synchronous clear.
module mac_lane #(
    parameter int unsigned N     = 8,
    parameter int unsigned ACC_W = 21
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [N-1:0]     x,
    input  logic signed [N-1:0]     w,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*N-1:0] prod_c;

    // Full-precision signed product.
    always_comb begin
        prod_c = x * w;
    end

    // Accumulator: clear wins over accumulate.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod_c);
        end
    end

endmodule

// File: rtl/dense_relu_engine.sv
// Frame-level dense layer: LANES parallel MACs sweep OUT_FEATURES dot products, then requantise.
module dense_relu_engine
    import dense_pkg::*;
#(
    parameter int unsigned N            = 8,
    parameter int unsigned IN_FEATURES  = 26,
    parameter int unsigned OUT_FEATURES = 128,
    parameter int unsigned LANES        = 4,
    parameter int unsigned ACC_W        = 2 * N + $clog2(IN_FEATURES),
    parameter int unsigned SHIFT        = 0
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             relu_en,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [IN_FEATURES*N-1:0]                         in_data,
    input  logic                                             wr_en,
    input  logic [$clog2(IN_FEATURES*OUT_FEATURES)-1:0]      wr_addr,
    input  logic [N-1:0]                                     wr_data,
    output logic                                             wr_err,
    output logic                                             busy,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [OUT_FEATURES*N-1:0]                        out_data
);

    localparam int unsigned G      = calc_groups(OUT_FEATURES, LANES);
    localparam int unsigned DEPTH  = IN_FEATURES * OUT_FEATURES;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned K_W    = calc_addr_w(IN_FEATURES);
    localparam int unsigned G_W    = calc_addr_w(G);

    if ((OUT_FEATURES % LANES) != 0) begin : g_bad_lanes
        $error("dense_relu_engine: OUT_FEATURES must be a multiple of LANES");
    end

    state_t                    state;
    logic [K_W-1:0]            k;
    logic [G_W-1:0]            grp;
    logic [IN_FEATURES*N-1:0]  x_q;
    logic                      relu_q;
    logic [N-1:0]              w_mem [DEPTH];

    logic signed [N-1:0]       x_cur_c;
    logic signed [N-1:0]       w_lane_c [LANES];
    logic signed [ACC_W-1:0]   acc [LANES];
    logic [N-1:0]              sat_lane_c [LANES];
    logic                      accept_c;
    logic                      lane_clr_c;
    logic                      lane_en_c;
    logic                      wr_ok_c;
    logic                      wr_bad_c;

    // Handshake, lane control and weight-write qualification.
    always_comb begin
        accept_c   = (state == IDLE) && in_ready && in_valid;
        lane_clr_c = accept_c || (state == WB);
        lane_en_c  = (state == MAC);
        wr_ok_c    = wr_en && ((state == IDLE) || (state == DONE))
                     && (32'(wr_addr) < DEPTH);
        wr_bad_c   = wr_en && !wr_ok_c;
    end

    // Current input element and per-lane weight read ports.
    always_comb begin
        x_cur_c = x_q[32'(k)*N +: N];
        for (int unsigned l = 0; l < LANES; l++) begin
            w_lane_c[l] = w_mem[ADDR_W'(32'(k)*OUT_FEATURES + 32'(grp)*LANES + l)];
        end
    end

    // Requantise each lane accumulator to an N-bit output element.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            sat_lane_c[l] = N'(sat_requant(64'(acc[l]), relu_q, N, SHIFT));
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane #(
            .N     (N),
            .ACC_W (ACC_W)
        ) u_mac_lane (
            .clk   (clk),
            .reset (reset),
            .clr   (lane_clr_c),
            .en    (lane_en_c),
            .x     (x_cur_c),
            .w     (w_lane_c[l]),
            .acc   (acc[l])
        );
    end

    // Weight memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            w_mem[wr_addr] <= wr_data;
        end
    end

    // Engine FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            wr_err    <= 1'b0;
            out_data  <= '0;
            k         <= '0;
            grp       <= '0;
            x_q       <= '0;
            relu_q    <= 1'b0;
        end else begin
            wr_err <= wr_bad_c;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        x_q      <= in_data;
                        relu_q   <= relu_en;
                        k        <= '0;
                        grp      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    if (k == K_W'(IN_FEATURES - 1)) begin
                        state <= WB;
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                WB: begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        out_data[(32'(grp)*LANES + l)*N +: N] <= sat_lane_c[l];
                    end
                    k <= '0;
                    if (grp == G_W'(G - 1)) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        grp   <= grp + G_W'(1);
                        state <= MAC;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dense_relu_engine.md
Name: dense_relu_engine

Overview:
Hardware replacement for the frame-level MFCC x weight matrix-multiply + ReLU stage that feeds relu_to_lstm. It accepts one feature frame of IN_FEATURES signed N-bit values and computes OUT_FEATURES dot products against an internal weight memory, using LANES parallel multiply-accumulate lanes. Each dot product is requantised with optional ReLU. The result is emitted as a packed vector, drop-in compatible with relu_to_lstm.relu_output.

Parameters:
N, 8, element width (inputs, weights, outputs), signed two's complement
IN_FEATURES, 26, elements per input frame (dot-product length K)
OUT_FEATURES, 128, output elements per frame
LANES, 4, parallel MAC lanes; OUT_FEATURES % LANES != 0 -> elaboration $error
ACC_W, 2*N+$clog2(IN_FEATURES), accumulator width, signed
SHIFT, 0, arithmetic right shift applied to accumulator before saturation

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high
relu_en  in  1  1 = ReLU clamp, 0 = signed saturation; sampled at frame accept
in_valid  in  1  frame offered
in_ready  out  1  engine can accept a frame (IDLE only)
in_data  in  IN_FEATURES*N  frame; element k = in_data[k*N +: N]
wr_en  in  1  weight write strobe
wr_addr  in  $clog2(IN_FEATURES*OUT_FEATURES)  address = k*OUT_FEATURES + j
wr_data  in  N  weight W[k][j]
wr_err  out  1  one-cycle pulse: write dropped (engine busy)
busy  out  1  high in MAC/WB
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  OUT_FEATURES*N  result; element j = out_data[j*N +: N]

Behaviour:
- Reset (any state, incl. mid-frame): next state IDLE; in_ready=1 after the reset cycle (0 while reset high); out_valid=0, busy=0, wr_err=0, out_data=0, accumulators=0, counters=0. Weight memory is not cleared.
- FSM: IDLE, MAC, WB, DONE. G = OUT_FEATURES/LANES groups.
- IDLE: in_ready=1. On in_valid: latch in_data and relu_en; set k=0, grp=0; clear accumulators; go to MAC.
- MAC: one cycle per k. Lane l: acc[l] += x[k]*W[k][grp*LANES+l], signed full-precision product, sign-extended to ACC_W. At k==IN_FEATURES-1, go to WB.
- WB: lane l result r = acc[l] >>> SHIFT.
  - relu_en=1: r<0 -> 0; r>2^(N-1)-1 -> 2^(N-1)-1.
  - relu_en=0: clamp to [-2^(N-1), 2^(N-1)-1].
  - Write to slot grp*LANES+l; clear accumulators; k=0.
  - grp==G-1 -> DONE, else grp++ and back to MAC.
- DONE: out_valid=1; out_data stable until handshake. On out_ready, go to IDLE the next cycle. A new frame is never accepted in the same cycle as the output handshake.
- Latency: out_valid rises exactly G*(IN_FEATURES+1)+1 cycles after the accept edge (130*? default: 32*27+1=865).
- out_data retains the last frame's values after the handshake until overwritten slot-by-slot in WB.
- Weight writes:
  - Committed on the clock edge in IDLE or DONE. A write in the accept cycle is visible to the frame just accepted.
  - A write in MAC/WB is dropped; wr_err pulses the following cycle.
  - Address >= IN_FEATURES*OUT_FEATURES: dropped, wr_err pulses.
- Accumulator: no overflow possible with default ACC_W; no wrap handling required.

Decomposition:
- Package dense_pkg: state_t enum (IDLE, MAC, WB, DONE); function sat_requant(acc, relu_en) parametrised by N/ACC_W/SHIFT; localparams G and ADDR_W helpers.
- One sub-module, mac_lane: holds the signed accumulator; inputs clr, en, x, w; output acc. Instantiated LANES times.
- Weight memory is an inferred array: LANES read ports, addressed k*OUT_FEATURES + grp*LANES + l.

Test Plan (bench config N=8, IN_FEATURES=4, OUT_FEATURES=8, LANES=2, SHIFT=0; latency 4*5+1=21):
1. Assert reset 2 cycles -> out_valid=0, busy=0, wr_err=0, out_data=0; in_ready=1 the cycle after reset drops.
2. All W=1, x={1,2,3,4}, relu_en=1 -> out_valid exactly 21 cycles after accept; all 8 outputs = 10 (0x0A).
3. All W=-1 (0xFF), same x -> relu_en=1: all outputs 0x00; relu_en=0: all outputs 0xF6 (-10).
4. x=all 127, W=all 127 -> 127 both modes. x=all -128, W=all 127, relu_en=0 -> -128 (0x80); relu_en=1 -> 0.
5. Hold out_ready=0 for 50 cycles -> out_valid, out_data stable, in_ready=0. Weight write during MAC -> wr_err pulse one cycle later; next frame shows the old weight.
6. Assert reset at cycle 7 of MAC -> busy=0 and out_valid=0 next cycle, back to IDLE. Resubmit frame from test 2 -> correct all-10 result at latency 21, with weights retained.
